// File: rtl/dff_pair_sequencer.sv
// Command/response sequencer for the two-flip-flop compare datapath.
// Loads D1/D2, waits for the registered f/g, and reports mismatches.
module dff_pair_sequencer #(
   parameter int CNT_W = 8
) (
   input  logic             CLK1,
   input  logic             RST,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [1:0]       rsp_data,
   output logic             rsp_err,
   output logic             D1,
   output logic             D2,
   input  logic             f,
   input  logic             g,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] txn_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             busy
);

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      LOAD,
      WAIT,
      RESP
   } state_t;

   state_t state_q, state_d;

   logic             d1_q, d1_d;
   logic             d2_q, d2_d;
   logic             fexp_q, fexp_d;
   logic             gexp_q, gexp_d;
   logic             rvld_q, rvld_d;
   logic [1:0]       rdata_q, rdata_d;
   logic             rerr_q, rerr_d;
   logic             crdy_q, crdy_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] txn_q, txn_d;
   logic [CNT_W-1:0] err_q, err_d;

   always_ff @(posedge CLK1) begin
      if (RST) begin
         state_q <= INIT;
         d1_q    <= 1'b0;
         d2_q    <= 1'b0;
         fexp_q  <= 1'b0;
         gexp_q  <= 1'b0;
         rvld_q  <= 1'b0;
         rdata_q <= 2'b00;
         rerr_q  <= 1'b0;
         crdy_q  <= 1'b0;
         busy_q  <= 1'b1;
         txn_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
         fexp_q  <= fexp_d;
         gexp_q  <= gexp_d;
         rvld_q  <= rvld_d;
         rdata_q <= rdata_d;
         rerr_q  <= rerr_d;
         crdy_q  <= crdy_d;
         busy_q  <= busy_d;
         txn_q   <= txn_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      d1_d    = d1_q;
      d2_d    = d2_q;
      fexp_d  = fexp_q;
      gexp_d  = gexp_q;
      rvld_d  = rvld_q;
      rdata_d = rdata_q;
      rerr_d  = rerr_q;
      txn_d   = txn_q;
      err_d   = err_q;
      unique case (state_q)
         INIT: state_d = IDLE;
         IDLE: begin
            if (cmd_valid && crdy_q) begin
               d1_d    = cmd_data[1];
               d2_d    = cmd_data[0];
               fexp_d  = cmd_data[1] & cmd_data[0];
               gexp_d  = ~cmd_data[1] | ~cmd_data[0];
               state_d = LOAD;
            end
         end
         LOAD: state_d = WAIT;
         WAIT: begin
            rdata_d = {f, g};
            rerr_d  = ({f, g} != {fexp_q, gexp_q});
            rvld_d  = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rvld_d  = 1'b0;
               txn_d   = txn_q + CNT_W'(1);
               if (rerr_q && !(&err_q))
                  err_d = err_q + CNT_W'(1);
               state_d = IDLE;
            end
         end
         default: state_d = INIT;
      endcase
      // clear overrides any increment in the same cycle
      if (clr_cnt) begin
         txn_d = '0;
         err_d = '0;
      end
      crdy_d = (state_d == IDLE);
      busy_d = (state_d != IDLE);
   end

   assign cmd_ready = crdy_q;
   assign rsp_valid = rvld_q;
   assign rsp_data  = rdata_q;
   assign rsp_err   = rerr_q;
   assign D1        = d1_q;
   assign D2        = d2_q;
   assign txn_cnt   = txn_q;
   assign err_cnt   = err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_dff_pair_sequencer.sv
// Bench for dff_pair_sequencer with a behavioural datapath and
// a transaction-level reference model.
module tb_dff_pair_sequencer;

   localparam int W = 3;
   localparam int MAXV = (1 << W) - 1;

   logic         CLK1 = 1'b0;
   logic         RST = 1'b1;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [1:0]   cmd_data = 2'b00;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [1:0]   rsp_data;
   logic         rsp_err;
   logic         D1, D2;
   logic         f_dut, g_dut;
   logic         clr_cnt = 1'b0;
   logic [W-1:0] txn_cnt, err_cnt;
   logic         busy;

   logic q1, q2, qb1, qb2;
   logic f_force = 1'b0;

   int total = 0;
   int bad = 0;
   int m_txn = 0;
   int m_err = 0;

   always #5 CLK1 = ~CLK1;

   // datapath: Q has reset, Q_bar does not
   always_ff @(posedge CLK1) begin
      if (RST) begin
         q1 <= 1'b0;
         q2 <= 1'b0;
      end else begin
         q1 <= D1;
         q2 <= D2;
      end
      qb1 <= ~D1;
      qb2 <= ~D2;
   end

   assign f_dut = f_force ? 1'b0 : (q1 && q2);
   assign g_dut = qb1 || qb2;

   dff_pair_sequencer #(.CNT_W(W)) dut (
      .CLK1      (CLK1),
      .RST       (RST),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .D1        (D1),
      .D2        (D2),
      .f         (f_dut),
      .g         (g_dut),
      .clr_cnt   (clr_cnt),
      .txn_cnt   (txn_cnt),
      .err_cnt   (err_cnt),
      .busy      (busy)
   );

   task automatic step();
      @(posedge CLK1);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag);
      chk({tag, "_txn"}, 32'(txn_cnt), 32'(m_txn));
      chk({tag, "_err"}, 32'(err_cnt), 32'(m_err));
   endtask

   task automatic do_reset();
      RST = 1'b1;
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      clr_cnt = 1'b0;
      f_force = 1'b0;
      step();
      step();
      m_txn = 0;
      m_err = 0;
      chk("rst_rdy", 32'(cmd_ready), 32'd0);
      chk("rst_vld", 32'(rsp_valid), 32'd0);
      chk("rst_data", 32'(rsp_data), 32'd0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      chk("rst_d", 32'({D1, D2}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk_cnt("rst");
      RST = 1'b0;
      step();
      chk("init_rdy", 32'(cmd_ready), 32'd1);
      chk("init_busy", 32'(busy), 32'd0);
      chk("init_fg", 32'({f_dut, g_dut}), 32'b01);
   endtask

   task automatic do_txn(input logic [1:0] d, input bit frc,
                         input int dly, input bit clr, input bit noise);
      logic [1:0] exp_d;
      logic       exp_e;
      logic       both;
      both  = d[1] & d[0];
      exp_d = {frc ? 1'b0 : both, ~both};
      exp_e = frc & both;
      chk("idle_rdy", 32'(cmd_ready), 32'd1);
      f_force = frc;
      cmd_valid = 1'b1;
      cmd_data = d;
      step();
      if (noise) cmd_data = ~d;
      else cmd_valid = 1'b0;
      chk("acc_rdy", 32'(cmd_ready), 32'd0);
      chk("acc_d", 32'({D1, D2}), 32'(d));
      chk("acc_vld", 32'(rsp_valid), 32'd0);
      chk("acc_busy", 32'(busy), 32'd1);
      step();
      chk("load_vld", 32'(rsp_valid), 32'd0);
      step();
      chk("rsp_vld", 32'(rsp_valid), 32'd1);
      chk("rsp_data", 32'(rsp_data), 32'(exp_d));
      chk("rsp_err", 32'(rsp_err), 32'(exp_e));
      for (int i = 0; i < dly; i++) begin
         step();
         chk("hold_vld", 32'(rsp_valid), 32'd1);
         chk("hold_data", 32'(rsp_data), 32'(exp_d));
         chk("hold_err", 32'(rsp_err), 32'(exp_e));
         chk("hold_rdy", 32'(cmd_ready), 32'd0);
         chk("hold_d", 32'({D1, D2}), 32'(d));
      end
      rsp_ready = 1'b1;
      cmd_valid = 1'b0;
      clr_cnt = clr;
      step();
      rsp_ready = 1'b0;
      clr_cnt = 1'b0;
      f_force = 1'b0;
      if (clr) begin
         m_txn = 0;
         m_err = 0;
      end else begin
         m_txn = (m_txn + 1) % (MAXV + 1);
         if (exp_e && m_err < MAXV) m_err = m_err + 1;
      end
      chk("done_vld", 32'(rsp_valid), 32'd0);
      chk("done_rdy", 32'(cmd_ready), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_d", 32'({D1, D2}), 32'(d));
      chk_cnt("done");
   endtask

   initial begin
      logic [1:0] rd;
      do_reset();

      for (int i = 0; i < 4; i++) begin
         rd = 2'(i);
         do_txn(rd, 1'b0, 0, 1'b0, 1'b0);
      end
      chk("tt_txn4", 32'(txn_cnt), 32'd4);

      do_txn(2'b11, 1'b0, 5, 1'b0, 1'b1);

      // reset while the response is being formed
      cmd_valid = 1'b1;
      cmd_data = 2'b10;
      step();
      cmd_valid = 1'b0;
      step();
      RST = 1'b1;
      step();
      chk("mid_vld", 32'(rsp_valid), 32'd0);
      chk("mid_rdy", 32'(cmd_ready), 32'd0);
      chk("mid_d", 32'({D1, D2}), 32'd0);
      chk("mid_busy", 32'(busy), 32'd1);
      m_txn = 0;
      m_err = 0;
      chk_cnt("mid");
      RST = 1'b0;
      step();
      chk("mid_idle", 32'(cmd_ready), 32'd1);
      chk("mid_novld", 32'(rsp_valid), 32'd0);

      for (int i = 0; i < 5; i++) begin
         rd = 2'($urandom_range(0, 3));
         do_txn(rd, 1'b0, 0, 1'b0, 1'b0);
      end
      chk("pre_clr", 32'(txn_cnt), 32'd5);
      do_txn(2'b01, 1'b0, 1, 1'b1, 1'b0);
      chk("clr_txn", 32'(txn_cnt), 32'd0);

      do_reset();
      for (int i = 0; i < MAXV + 2; i++)
         do_txn(2'b11, 1'b1, 0, 1'b0, 1'b0);
      chk("sat_err", 32'(err_cnt), 32'(MAXV));
      chk("wrap_txn", 32'(txn_cnt), 32'd1);

      for (int i = 0; i < 40; i++) begin
         rd = 2'($urandom_range(0, 3));
         do_txn(rd, ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 1) == 1));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
